// File: rtl/bcd_pkg.sv
// ----------------------------------------------------------------------------
// bcd_pkg
// Shared definitions for the sequential binary-to-BCD converter.
//   state_t     : converter FSM states (IDLE, SHIFT, DONE)
//   bcd_digits  : number of decimal digits needed for a 'width'-bit unsigned
//                 value, using log10(2) ~= 0.301
// ----------------------------------------------------------------------------
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int bcd_digits(input int width);
        return (width * 301) / 1000 + 1;
    endfunction

endpackage

// File: rtl/bcd_add3_digit.sv
// ----------------------------------------------------------------------------
// bcd_add3_digit
// Double-dabble correction for one BCD digit: a digit of 5..9 gets 3 added
// so that the following left shift carries correctly into the next digit.
// Ports:
//   din  : 4-bit BCD digit before correction
//   dout : 4-bit corrected digit
// ----------------------------------------------------------------------------
module bcd_add3_digit (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    always_comb begin
        dout = din;
        if (din >= 4'd5) begin
            dout = din + 4'd3;
        end
    end

endmodule

// File: rtl/binary_to_bcd_seq.sv
// ----------------------------------------------------------------------------
// binary_to_bcd_seq
// Sequential double-dabble binary-to-BCD converter, one bit per clock.
// Parameters:
//   WIDTH  : binary input width (4..32)
//   SIGNED : 1 = two's-complement input, 0 = unsigned
//   DIGITS : number of BCD output digits
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   in_valid   : in_data valid this cycle
//   in_ready   : converter idle and able to accept an operand
//   in_data    : binary operand
//   out_valid  : bcd_out / neg_out hold a finished result
//   out_ready  : consumer takes the result this cycle
//   bcd_out    : packed BCD digits, digit 0 (ones) in bits [3:0]
//   neg_out    : result is negative (always 0 when SIGNED = 0)
//
// Handshake: a transfer happens on any rising edge where valid and ready are
// both 1. The converter never queues: in_ready is high only in IDLE, and
// out_valid is high only in DONE, where the result is held until out_ready.
// ----------------------------------------------------------------------------
module binary_to_bcd_seq
    import bcd_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter bit SIGNED = 1'b0,
    parameter int DIGITS = bcd_digits(WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic                  neg_out
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int BW = 4 * DIGITS;

    state_t            state_q, state_d;
    logic [BW-1:0]     acc_q, acc_d;
    logic [WIDTH-1:0]  op_q, op_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic              neg_q, neg_d;

    logic [BW-1:0]     acc_corr;
    logic              is_neg;
    logic [WIDTH-1:0]  cap_mag;

    // Per-digit add-3 correction applied before every shift.
    for (genvar g = 0; g < DIGITS; g++) begin : g_digit
        bcd_add3_digit u_add3 (
            .din  (acc_q[4*g +: 4]),
            .dout (acc_corr[4*g +: 4])
        );
    end

    // Magnitude of the operand. The (WIDTH+1)-bit negation of a negative
    // WIDTH-bit value always has a zero top bit, so WIDTH bits hold it
    // exactly, including the most negative value 2^(WIDTH-1).
    always_comb begin
        is_neg  = SIGNED && in_data[WIDTH-1];
        cap_mag = in_data;
        if (is_neg) begin
            cap_mag = ~in_data + WIDTH'(1);
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        op_d    = op_q;
        cnt_d   = cnt_q;
        neg_d   = neg_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    acc_d   = '0;
                    op_d    = cap_mag;
                    cnt_d   = CW'(WIDTH);
                    neg_d   = is_neg;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                // {acc, op} << 1 with the corrected digits; the accumulator's
                // top bit can never be set because DIGITS covers the range.
                acc_d = BW'({acc_corr, op_q[WIDTH-1]});
                op_d  = {op_q[WIDTH-2:0], 1'b0};
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            op_q    <= '0;
            cnt_q   <= '0;
            neg_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            op_q    <= op_d;
            cnt_q   <= cnt_d;
            neg_q   <= neg_d;
        end
    end

    // Outputs are gated by DONE so a partial accumulator is never visible.
    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        bcd_out   = out_valid ? acc_q : '0;
        neg_out   = out_valid & neg_q;
    end

endmodule

// File: tb/tb_binary_to_bcd_seq.sv
// ----------------------------------------------------------------------------
// tb_binary_to_bcd_seq
// Three converter instances share one clock and reset:
//   sel 0 : WIDTH=8,  SIGNED=0
//   sel 1 : WIDTH=8,  SIGNED=1
//   sel 2 : WIDTH=16, SIGNED=0
// Expected results ({neg, 20-bit BCD}) are queued when an operand is driven
// and compared when the selected instance presents its result.
// ----------------------------------------------------------------------------
module tb_binary_to_bcd_seq;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [2:0]  in_valid;
    logic [2:0]  out_ready;
    logic [15:0] in_data;

    logic        ir_a, ov_a, neg_a;
    logic [11:0] bcd_a;
    logic        ir_b, ov_b, neg_b;
    logic [11:0] bcd_b;
    logic        ir_c, ov_c, neg_c;
    logic [19:0] bcd_c;

    binary_to_bcd_seq #(.WIDTH(8), .SIGNED(1'b0)) u_u8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(ir_a),
        .in_data(in_data[7:0]), .out_valid(ov_a), .out_ready(out_ready[0]),
        .bcd_out(bcd_a), .neg_out(neg_a)
    );

    binary_to_bcd_seq #(.WIDTH(8), .SIGNED(1'b1)) u_s8 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(ir_b),
        .in_data(in_data[7:0]), .out_valid(ov_b), .out_ready(out_ready[1]),
        .bcd_out(bcd_b), .neg_out(neg_b)
    );

    binary_to_bcd_seq #(.WIDTH(16), .SIGNED(1'b0)) u_u16 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid[2]), .in_ready(ir_c),
        .in_data(in_data), .out_valid(ov_c), .out_ready(out_ready[2]),
        .bcd_out(bcd_c), .neg_out(neg_c)
    );

    // ---------------- scoreboard state ----------------
    int          vectors = 0;
    int          errors  = 0;
    int          sel     = 0;
    logic [20:0] exp_q[$];

    function automatic int width_of(input int s);
        return (s == 2) ? 16 : 8;
    endfunction

    function automatic logic get_ir();
        case (sel)
            0:       return ir_a;
            1:       return ir_b;
            default: return ir_c;
        endcase
    endfunction

    function automatic logic get_ov();
        case (sel)
            0:       return ov_a;
            1:       return ov_b;
            default: return ov_c;
        endcase
    endfunction

    function automatic logic [20:0] get_res();
        case (sel)
            0:       return {neg_a, 8'h00, bcd_a};
            1:       return {neg_b, 8'h00, bcd_b};
            default: return {neg_c, bcd_c};
        endcase
    endfunction

    // Reference: decimal digits by repeated division.
    function automatic logic [20:0] ref_model(input int unsigned v, input int w, input bit sgn);
        longint unsigned mag;
        logic            neg;
        logic [19:0]     bcd;
        mag = v;
        mag = mag & ((64'd1 << w) - 64'd1);
        neg = 1'b0;
        if (sgn && (((mag >> (w - 1)) & 64'd1) == 64'd1)) begin
            neg = 1'b1;
            mag = (64'd1 << w) - mag;
        end
        bcd = '0;
        for (int d = 0; d < 5; d++) begin
            bcd[4*d +: 4] = 4'(mag % 10);
            mag = mag / 10;
        end
        return {neg, bcd};
    endfunction

    // ---------------- driver tasks ----------------
    task automatic wait_ready();
        int n;
        n = 0;
        while (!get_ir() && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!get_ir()) begin
            vectors++; errors++;
            $display("FAIL ready_timeout sel=%0d in_ready=%b want 1", sel, get_ir());
        end
    endtask

    // One full conversion: drive, check latency, compare result, hand off.
    task automatic convert(input logic [15:0] data, input logic [20:0] exp, input bit hold_ready);
        int          lat;
        logic [20:0] want;
        logic [20:0] got;
        bit          digits_ok;
        wait_ready();
        out_ready[sel] = hold_ready;
        in_data        = data;
        in_valid[sel]  = 1'b1;
        exp_q.push_back(exp);
        @(posedge clk); #1;
        in_valid[sel] = 1'b0;
        lat = 0;
        while (!get_ov() && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
        vectors++;
        if (lat != width_of(sel)) begin
            errors++;
            $display("FAIL latency sel=%0d data=%h got %0d edges want %0d", sel, data, lat, width_of(sel));
        end
        want = exp_q.pop_front();
        got  = get_res();
        vectors++;
        if (got !== want) begin
            errors++;
            $display("FAIL result sel=%0d data=%h got neg=%b bcd=%h want neg=%b bcd=%h",
                     sel, data, got[20], got[19:0], want[20], want[19:0]);
        end
        digits_ok = 1'b1;
        for (int d = 0; d < 5; d++) begin
            if (got[4*d +: 4] > 4'd9) digits_ok = 1'b0;
        end
        vectors++;
        if (!digits_ok) begin
            errors++;
            $display("FAIL digit_range sel=%0d data=%h bcd=%h", sel, data, got[19:0]);
        end
        out_ready[sel] = 1'b1;
        @(posedge clk); #1;
        out_ready[sel] = hold_ready;
        vectors++;
        if (get_ov() !== 1'b0 || get_ir() !== 1'b1) begin
            errors++;
            $display("FAIL handoff sel=%0d out_valid=%b in_ready=%b want 0/1", sel, get_ov(), get_ir());
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = '0;
        out_ready = '0;
        in_data   = '0;
        repeat (3) @(posedge clk);
        #2;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            vectors++;
            if (get_ov() !== 1'b0 || get_res() !== 21'd0) begin
                errors++;
                $display("FAIL reset_outputs sel=%0d out_valid=%b res=%h want 0/0", s, get_ov(), get_res());
            end
        end
        rst_n = 1'b1;
        #1;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            vectors++;
            if (get_ir() !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready sel=%0d in_ready=%b want 1", s, get_ir());
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic test_unsigned8();
        sel = 0;
        convert(16'd255, {1'b0, 20'h00255}, 1'b0);
        convert(16'd0,   {1'b0, 20'h00000}, 1'b0);
        convert(16'd100, {1'b0, 20'h00100}, 1'b0);
        convert(16'd9,   {1'b0, 20'h00009}, 1'b0);
    endtask

    task automatic test_signed8();
        sel = 1;
        convert(16'h0080, {1'b1, 20'h00128}, 1'b0);
        convert(16'h00FF, {1'b1, 20'h00001}, 1'b0);
        convert(16'h0000, {1'b0, 20'h00000}, 1'b0);
        convert(16'h007F, {1'b0, 20'h00127}, 1'b0);
    endtask

    task automatic test_wide16();
        sel = 2;
        convert(16'd65535, {1'b0, 20'h65535}, 1'b0);
        convert(16'd0,     {1'b0, 20'h00000}, 1'b0);
        convert(16'd10000, {1'b0, 20'h10000}, 1'b0);
    endtask

    task automatic test_backpressure();
        int          n;
        logic [20:0] want;
        bit          stray;
        sel = 0;
        wait_ready();
        out_ready[0] = 1'b0;
        in_data      = 16'd173;
        in_valid[0]  = 1'b1;
        exp_q.push_back({1'b0, 20'h00173});
        @(posedge clk); #1;
        in_valid[0] = 1'b0;
        n = 0;
        while (!get_ov() && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        want = exp_q.pop_front();
        for (int c = 0; c < 10; c++) begin
            vectors++;
            if (get_ov() !== 1'b1 || get_res() !== want || get_ir() !== 1'b0) begin
                errors++;
                $display("FAIL backpressure_hold cycle=%0d out_valid=%b res=%h in_ready=%b want 1/%h/0",
                         c, get_ov(), get_res(), get_ir(), want);
            end
            if (c == 3) begin
                in_data     = 16'd42;
                in_valid[0] = 1'b1;
            end else begin
                in_valid[0] = 1'b0;
            end
            @(posedge clk); #1;
        end
        out_ready[0] = 1'b1;
        @(posedge clk); #1;
        out_ready[0] = 1'b0;
        vectors++;
        if (get_ov() !== 1'b0 || get_ir() !== 1'b1) begin
            errors++;
            $display("FAIL backpressure_release out_valid=%b in_ready=%b want 0/1", get_ov(), get_ir());
        end
        stray = 1'b0;
        repeat (12) begin
            @(posedge clk); #1;
            if (get_ov() !== 1'b0 || get_ir() !== 1'b1) stray = 1'b1;
        end
        vectors++;
        if (stray) begin
            errors++;
            $display("FAIL ignored_input got a queued conversion, want none");
        end
    endtask

    task automatic test_reset_abort();
        bit leaked;
        sel = 1;
        wait_ready();
        in_data     = 16'h009C;
        in_valid[1] = 1'b1;
        @(posedge clk); #1;
        in_valid[1] = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #2;
        vectors++;
        if (get_ov() !== 1'b0 || get_res() !== 21'd0) begin
            errors++;
            $display("FAIL abort_in_reset out_valid=%b res=%h want 0/0", get_ov(), get_res());
        end
        #2;
        rst_n = 1'b1;
        #1;
        vectors++;
        if (get_ir() !== 1'b1) begin
            errors++;
            $display("FAIL abort_ready in_ready=%b want 1", get_ir());
        end
        leaked = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (get_ov() !== 1'b0) leaked = 1'b1;
        end
        vectors++;
        if (leaked) begin
            errors++;
            $display("FAIL abort_discard out_valid asserted after aborted conversion, want never");
        end
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 2; s++) begin
            sel = s;
            for (int i = 0; i < 256; i++) begin
                convert(16'(i), ref_model(i, 8, s == 1), 1'b1);
            end
            out_ready[s] = 1'b0;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_unsigned8();
        test_signed8();
        test_wide16();
        test_backpressure();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/binary_to_bcd_seq.md
BINARY_TO_BCD_SEQ -- requirements
Module: binary_to_bcd_seq

Interface
REQ-001 Parameter WIDTH, default 8: binary input width in bits, legal range 4..32.
REQ-002 Parameter SIGNED, default 0: 1 treats the input as two's complement; 0 treats it as unsigned.
REQ-003 Parameter DIGITS, default (WIDTH*301)/1000+1 using integer division: number of BCD output digits.
REQ-004 Port clk  input  1: single clock; all state updates occur on its rising edge.
REQ-005 Port rst_n  input  1: reset, asynchronous and active-low.
REQ-006 Port in_valid  input  1: in_data is valid this cycle.
REQ-007 Port in_ready  output  1: block can accept an input this cycle.
REQ-008 Port in_data  input  WIDTH: binary value to convert.
REQ-009 Port out_valid  output  1: bcd_out and neg_out are valid.
REQ-010 Port out_ready  input  1: consumer accepts the result this cycle.
REQ-011 Port bcd_out  output  4*DIGITS: packed BCD result; digit 0 (ones) occupies bits [3:0].
REQ-012 Port neg_out  output  1: result is negative; held at 0 when SIGNED=0.

Function
REQ-013 The block SHALL use a three-state FSM: IDLE, SHIFT, DONE.
REQ-014 In IDLE, in_ready SHALL be 1; in SHIFT and DONE, in_ready SHALL be 0.
REQ-015 A transfer SHALL occur on a rising edge where in_valid=1 and in_ready=1; at that edge the block SHALL capture the operand, clear the BCD accumulator, load the bit counter with WIDTH, and enter SHIFT.
REQ-016 When SIGNED=1 and in_data[WIDTH-1]=1, the block SHALL capture the magnitude (two's-complement negation, WIDTH+1-bit internal) and set the neg flag; otherwise neg=0.
REQ-017 Each SHIFT cycle SHALL do the following, then decrement the counter:
- add 3 to every accumulator digit whose value is >=5;
- shift {accumulator, operand} left by one bit, taking in the operand MSB.
REQ-018 The block SHALL leave SHIFT for DONE on the edge that performs the final shift (counter reaching 0), after exactly WIDTH shift cycles.
REQ-019 When SIGNED=1, SHIFT SHALL run WIDTH shift cycles over the WIDTH-bit magnitude; the magnitude 2^(WIDTH-1) SHALL be represented exactly.
REQ-020 out_valid SHALL be 1 only in DONE, which it reaches exactly WIDTH rising edges after the accepting edge (latency WIDTH cycles; throughput one result per WIDTH+2 cycles minimum).
REQ-021 In DONE, bcd_out and neg_out SHALL be stable and equal to the decimal value of the captured operand.
REQ-022 DONE SHALL persist while out_ready=0.
REQ-023 The edge with out_valid=1 and out_ready=1 SHALL return the FSM to IDLE.
REQ-024 in_valid asserted outside IDLE SHALL be ignored; no input is queued.
REQ-025 out_ready asserted outside DONE SHALL have no effect.
REQ-026 bcd_out SHALL read 0 whenever out_valid=0.
REQ-027 Each BCD digit SHALL remain within 0..9 at all times.
REQ-028 Unused high digits SHALL be 0.
REQ-029 Input value 0 SHALL produce all-zero digits with neg_out=0, including for SIGNED=1.

Reset
REQ-030 When rst_n=0, the block SHALL asynchronously force: FSM=IDLE, accumulator=0, operand=0, counter=0, neg=0, out_valid=0, bcd_out=0, neg_out=0.
REQ-031 in_ready SHALL read 1 immediately after rst_n deasserts, with no warm-up cycles.
REQ-032 Reset asserted mid-SHIFT or in DONE SHALL abort the conversion and discard the result; no partial result SHALL ever be presented.

Structure
REQ-033 Package bcd_pkg SHALL hold the state enumeration type (IDLE/SHIFT/DONE) and the digit-count function used for the DIGITS default.
REQ-034 The per-digit correction (>=5 -> +3, 4-bit in/out) SHALL be a combinational sub-module bcd_add3_digit, instantiated DIGITS times via generate.
REQ-035 The counter width SHALL be $clog2(WIDTH+1).

Verification
REQ-036 The bench SHALL cover: WIDTH=8, SIGNED=0, in_data=8'd255 -> out_valid after 8 edges, bcd_out=12'h255, neg_out=0.
REQ-037 The bench SHALL cover: WIDTH=8, SIGNED=1, in_data=8'h80 -> bcd_out=12'h128, neg_out=1; in_data=8'hFF -> bcd_out=12'h001, neg_out=1.
REQ-038 The bench SHALL cover: WIDTH=16, SIGNED=0, in_data=16'd65535 -> DIGITS=5, bcd_out=20'h65535; in_data=0 -> 20'h00000.
REQ-039 The bench SHALL cover backpressure: out_ready=0 for 10 cycles -> out_valid and bcd_out held, in_ready=0 throughout, and a second in_valid pulse ignored.
REQ-040 The bench SHALL cover reset abort: rst_n pulsed low at the 4th SHIFT cycle -> out_valid never asserts for that operand; in_ready=1 after release.
REQ-041 The bench SHALL cover an exhaustive sweep: all 256 WIDTH=8 inputs, both SIGNED modes, back-to-back with out_ready=1 -> every result matches a reference model and every digit is <=9.
